imem_program_encoder: RTL
=========================

Name: imem_program_encoder

Overview:
- Encodes a stream of symbolic RV32I instruction requests (op selector plus rd, rs1, rs2 and imm) into 32-bit machine words.
- Writes each word sequentially into instruction memory, starting at the reset PC.
- Covers exactly the subset the core's control unit decodes: lw, sw, R-type add/sub/slt/or/and, I-type addi/slti/ori/andi, and beq.
- Sits between the test/boot loader and the instruction memory write port; it is the encode side of the decoder.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of the first word written (the reset PC).
- MAX_WORDS, 1024, capacity of the program region, in words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a new program load; clears count and error.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder accepts a request this cycle.
- in_last  in  1  request is the final instruction of the program.
- in_op  in  4  0 LW, 1 SW, 2 ADD, 3 SUB, 4 SLT, 5 OR, 6 AND, 7 ADDI, 8 SLTI, 9 ORI, 10 ANDI, 11 BEQ; 12-15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  13  signed immediate, byte offset for BEQ.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  32  write byte address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last word is written.
- error  out  1  sticky error flag.
- err_code  out  2  0 illegal op, 1 immediate out of range, 2 BEQ offset odd, 3 capacity overflow.
- count  out  16  words written in the current load.

Behaviour:
- Reset values: state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, error=0, err_code=0, count=0.
- rst mid-load aborts the load: mem_we=0 from the next cycle, and no further words are written.
- FSM states: IDLE, RUN, DONE, ERR.
- IDLE or ERR + start → RUN; count=0, error=0, err_code=0.
- start in RUN or DONE is ignored.
- in_valid outside RUN is never accepted.
- in_ready = (state==RUN).
- Accept = in_valid & in_ready, sampled on a rising edge.
- Valid accept, at the same edge:
  - mem_we=1, mem_addr=BASE_ADDR+4*count, mem_wdata=encode(op, fields), count+1.
  - mem_we stays high for exactly the following cycle (latency 1); back-to-back accepts give consecutive writes.
- Accept with in_last=1 and no error → DONE. DONE lasts one cycle with done=1, then → IDLE.
- Error checks, evaluated at accept in priority order illegal op > range > misaligned > overflow:
  - in_op ≥ 12 → code 0.
  - For LW/SW/I-type, in_imm[12]≠in_imm[11] → code 1.
  - For BEQ, in_imm[0]=1 → code 2.
  - count==MAX_WORDS → code 3.
  - On any error: no write, error=1, err_code latched, → ERR. in_ready=0 until the next start.
- in_imm is ignored for R-type ops, as is in_rs2 for LW/I-type and in_rd for SW/BEQ; these fields never raise errors.
- Encodings (I = imm[11:0]; B = imm[12:1]):
  - LW: I|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - R-type: f7|rs2|rs1|f3|rd|0110011. f7=0100000 for SUB, 0000000 otherwise. f3: ADD/SUB 000, SLT 010, OR 110, AND 111.
  - I-type: I|rs1|f3|rd|0010011, with f3 as for the matching R-op.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
1. Single ADDI, last:
   - Stimulus: start; ADDI rd=1 rs1=0 imm=5, in_last=1.
   - Response: mem_we for one cycle, addr 0x1000, data 0x00500093; then done pulse; count=1; back in IDLE.
2. Four-instruction load, back-to-back valid:
   - Stimulus: LW x2,8(x1); SW x2,12(x1); SUB x3,x1,x2; BEQ x1,x2,-4 (last).
   - Response: writes 0x0080A103 @0x1000, 0x0020A623 @0x1004, 0x402081B3 @0x1008, 0xFE208EE3 @0x100C on consecutive cycles; done pulse; count=4.
3. Error cases:
   - ADDI imm=2048 → no write, error=1, err_code=1, in_ready=0.
   - New start, then BEQ imm=3 → err_code=2.
   - New start, then in_op=15 → err_code=0.
4. Overflow:
   - Stimulus: MAX_WORDS=2; send three ADDIs.
   - Response: two writes, then error with err_code=3 and no third write.
5. Reset mid-load:
   - Stimulus: assert rst in the cycle after the second accept.
   - Response: mem_we=0, count=0, state IDLE; later in_valid is not accepted (in_ready=0).
6. Ignored inputs:
   - Stimulus: start pulse while in RUN.
   - Response: count and addresses continue, not restarted.
   - Stimulus: in_valid in IDLE.
   - Response: no write, count unchanged.

Source files
------------

// File: rtl/imem_program_encoder.sv
// Encodes symbolic RV32I requests (lw/sw/R-type/I-type/beq) into machine words
// and streams them into instruction memory starting at the reset PC.
module imem_program_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [12:0] in_imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LW   = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SLTI = 4'd8;
  localparam logic [3:0] OP_ORI  = 4'd9;
  localparam logic [3:0] OP_ANDI = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t state, next_state;

  logic       accept;
  logic       start_ok;
  logic       uses_imm12;
  logic       err_hit;
  logic [1:0] err_sel;

  // Shared funct3 for an R-op and its I-type twin.
  function automatic logic [2:0] funct3(input logic [3:0] op);
    case (op)
      OP_SLT, OP_SLTI: funct3 = 3'b010;
      OP_OR,  OP_ORI:  funct3 = 3'b110;
      OP_AND, OP_ANDI: funct3 = 3'b111;
      default:         funct3 = 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [3:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [12:0] imm);
    logic [6:0] f7;
    f7 = (op == OP_SUB) ? 7'b0100000 : 7'b0000000;
    case (op)
      OP_LW:
        encode = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_SW:
        encode = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_ADD, OP_SUB, OP_SLT, OP_OR, OP_AND:
        encode = {f7, rs2, rs1, funct3(op), rd, 7'b0110011};
      OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI:
        encode = {imm[11:0], rs1, funct3(op), rd, 7'b0010011};
      OP_BEQ:
        encode = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default:
        encode = 32'h0000_0000;
    endcase
  endfunction

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state (high in RUN), never on in_valid.
  assign in_ready  = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign state_dbg = state;

  always_comb begin
    accept     = in_valid && (state == S_RUN);
    start_ok   = start && ((state == S_IDLE) || (state == S_ERR));
    uses_imm12 = (in_op == OP_LW) || (in_op == OP_SW) ||
                 ((in_op >= OP_ADDI) && (in_op <= OP_ANDI));
    err_hit    = 1'b1;
    err_sel    = 2'd0;
    if (in_op >= 4'd12) begin
      err_sel = 2'd0;
    end else if (uses_imm12 && (in_imm[12] != in_imm[11])) begin
      err_sel = 2'd1;
    end else if ((in_op == OP_BEQ) && in_imm[0]) begin
      err_sel = 2'd2;
    end else if (count == MAX_CNT) begin
      err_sel = 2'd3;
    end else begin
      err_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_ERR: if (start_ok) next_state = S_RUN;
      S_RUN: begin
        if (accept) begin
          if (err_hit)      next_state = S_ERR;
          else if (in_last) next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      count     <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (start_ok) begin
        count    <= 16'd0;
        error    <= 1'b0;
        err_code <= 2'd0;
      end
      if (accept) begin
        if (err_hit) begin
          error    <= 1'b1;
          err_code <= err_sel;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= BASE_ADDR + {14'd0, count, 2'b00};
          mem_wdata <= encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
          count     <= count + 16'd1;
          done      <= in_last;
        end
      end
    end
  end

endmodule
